// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: operation encodings, FSM
// state encoding and the bit positions of the NZCV flags inside ALUFlags.
package alu_pkg;

  // Operation select as presented on ALUControl.
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_LSL = 3'b101,
    OP_LSR = 3'b110,
    OP_MUL = 3'b111
  } alu_op_t;

  // Request/response FSM: IDLE accepts, BUSY runs the multiplier,
  // DONE presents the registered result until the consumer takes it.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit positions of the flags inside the 4-bit {N,Z,C,V} vector.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage : alu_pkg

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier producing the low WIDTH bits of a*b.
// A start pulse latches the operands and runs WIDTH steps, one per clock.
// done is high during the final step; product is the accumulator value
// that step produces, so the caller can register it on the same edge.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  // Counter must be able to hold the value WIDTH itself.
  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] step_acc;

  // Accumulator value after the current step; only the low WIDTH bits
  // are kept, so partial products shifted past the top simply drop out.
  assign step_acc = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  assign busy    = busy_q;
  assign done    = busy_q && (cnt_q == CW'(1));
  assign product = step_acc;

  // Next-state logic: load on start, otherwise advance one step while busy.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path
    // leaves a variable unassigned and no latch is inferred.
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start) begin
      mcand_d  = a;
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = CW'(WIDTH);
      busy_d   = 1'b1;
    end else if (busy_q) begin
      acc_d    = step_acc;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
      end
    end
  end

  // State registers with asynchronous active-high clear.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the datapath registers are cleared along with the control
    // flops so an aborted multiply leaves no stale operands behind.
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here; all flops sample their
      // _d inputs from the same pre-edge values.
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

endmodule : alu_mul_iter

// File: rtl/alu_seq.sv
// Handshaked sequential ALU. Single-cycle ops (add, sub, logic, shifts)
// are registered one cycle after acceptance; MUL is handed to the
// iterative multiplier and completes WIDTH+1 cycles after acceptance.
// Result and ALUFlags stay stable while out_valid is high.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       ALUFlags
);

  // Shift amount field width follows from WIDTH and is not adjustable.
  localparam int SHW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;

  alu_op_t          op;
  logic             accept;
  logic [SHW-1:0]   sh_amt;

  logic [WIDTH:0]   add_wide;
  logic [WIDTH:0]   sub_wide;
  logic [WIDTH:0]   lsl_wide;
  logic [WIDTH:0]   lsr_wide;

  logic [WIDTH-1:0] alu_r;
  logic             alu_c;
  logic             alu_v;

  logic             mul_start;
  logic             mul_busy;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  // Pack a result with its carry/overflow into the {N,Z,C,V} layout.
  function automatic logic [3:0] pack_flags(input logic [WIDTH-1:0] r,
                                            input logic             c,
                                            input logic             v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = r[WIDTH-1];
    f[FLAG_Z] = (r == '0);
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

  assign op     = alu_op_t'(ALUControl);
  assign sh_amt = b[SHW-1:0];

  // Only IDLE accepts; the multiplier-busy term is a defensive interlock.
  assign in_ready  = (state_q == ST_IDLE) && !mul_busy;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_DONE);
  assign Result    = result_q;
  assign ALUFlags  = flags_q;

  // Single-cycle datapath: every op computed in parallel, one selected.
  always_comb begin
    // Carry-out lands in the extra top bit of each widened sum.
    add_wide = {1'b0, a} + {1'b0, b};
    sub_wide = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    // Left shift through an extra top bit: the last bit shifted out of
    // a[WIDTH-1] ends up at bit WIDTH, which is zero for a zero shift.
    lsl_wide = {1'b0, a} << sh_amt;
    // Right shift through an extra bottom bit: the last bit shifted out
    // of a[0] ends up at bit 0, which is zero for a zero shift.
    lsr_wide = {a, 1'b0} >> sh_amt;

    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (op)
      OP_ADD: begin
        alu_r = add_wide[WIDTH-1:0];
        alu_c = add_wide[WIDTH];
        // Overflow: operands share a sign that the result does not.
        alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (alu_r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_r = sub_wide[WIDTH-1:0];
        alu_c = sub_wide[WIDTH];
        // Overflow: operand signs differ and the result flips from a's.
        alu_v = (a[WIDTH-1] != b[WIDTH-1]) && (alu_r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: alu_r = a & b;
      OP_OR:  alu_r = a | b;
      OP_XOR: alu_r = a ^ b;
      OP_LSL: begin
        alu_r = lsl_wide[WIDTH-1:0];
        alu_c = lsl_wide[WIDTH];
      end
      OP_LSR: begin
        alu_r = lsr_wide[WIDTH:1];
        alu_c = lsr_wide[0];
      end
      default: begin
        // MUL is produced by the iterative multiplier, not this path.
        alu_r = '0;
      end
    endcase
  end

  // Control FSM: accept, run the multiplier if needed, hold the result.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    flags_d   = flags_q;
    mul_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (op == OP_MUL) begin
            mul_start = 1'b1;
            state_d   = ST_BUSY;
          end else begin
            result_d = alu_r;
            flags_d  = pack_flags(alu_r, alu_c, alu_v);
            state_d  = ST_DONE;
          end
        end
      end
      ST_BUSY: begin
        // The final multiplier step and the result register share an edge.
        if (mul_done) begin
          result_d = mul_product;
          flags_d  = pack_flags(mul_product, 1'b0, 1'b0);
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM and output registers; reset discards any op in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  alu_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

endmodule : alu_seq
